ysyx_22041752_isram_bridge: RTL and testbench
=============================================

# ysyx_22041752_isram_bridge

Instruction-side responder for the IF-stage fetch handshake (`inst_en` / `inst_ready` / `inst_addr` / `inst_valid` / `inst_rdata`). It converts each accepted fetch request into one AXI4-Lite read transaction (AR/R channels) toward instruction memory. It selects the 32-bit instruction from the returned data beat and holds it stable for the fetch stage. It sits between the IFU and the core's memory-side AXI arbiter, one instance per core.

## Interface
- `ADDR_WD`, 32: fetch and AXI address width.
- `DATA_WD`, 64: AXI read-data width and `inst_rdata` width.
- `INST_WD`, 32: instruction width. `DATA_WD` is a multiple of `INST_WD`.
- `RESET_ARADDR`, 0: reset value of `araddr`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inst_en` in 1: fetch request; accepted when `inst_en && inst_ready`.
- `inst_addr` in ADDR_WD: fetch byte address, sampled on acceptance.
- `inst_ready` out 1: bridge can accept a request this cycle.
- `inst_valid` out 1: `inst_rdata` holds the result of the last accepted request.
- `inst_rdata` out DATA_WD: bits [INST_WD-1:0] hold the selected instruction; upper bits are 0.
- `inst_err` out 1: qualifies `inst_valid`; the fetch faulted.
- `arvalid` out 1, `arready` in 1, `araddr` out ADDR_WD: AXI read-address channel. `arprot` is tied to 3'b100.
- `rvalid` in 1, `rready` out 1, `rdata` in DATA_WD, `rresp` in 2: AXI read-data channel.

## Operation
- FSM states: IDLE, ADDR, DATA, FAULT. Reset state is IDLE.
- IDLE:
  - `inst_ready`=1.
  - On acceptance, latch `inst_addr` into `req_addr` and clear `inst_valid` and `inst_err`.
  - If `inst_addr[1:0]`!=0, go to FAULT. Otherwise go to ADDR.
- ADDR:
  - `arvalid`=1 and `araddr`=`req_addr` with the low log2(DATA_WD/8) bits zeroed.
  - `araddr` is stable while `arvalid` is high and `arready` is low.
  - On `arready`, go to DATA.
- DATA:
  - `rready`=1.
  - On `rvalid`, capture the INST_WD slice of `rdata` indexed by `req_addr[log2(DATA_WD/8)-1:2]`.
  - Set `inst_valid`=1 and `inst_err`=(`rresp`!=2'b00). Go to IDLE.
- FAULT: next cycle, `inst_rdata`=0, `inst_valid`=1, `inst_err`=1. Go to IDLE.
- `inst_valid`, `inst_rdata` and `inst_err` are registered. They hold their values in IDLE until the next acceptance, which clears `inst_valid` in the following cycle.
- `inst_ready`=0 in ADDR, DATA and FAULT. Requests presented then are ignored, not queued.
- Once AR has been issued, the transaction always completes. IFU flush or branch redirects are invisible to the bridge; the IFU discards the stale result itself.
- Only one transaction is ever outstanding. No AR is issued while an R beat is pending.

## Timing
- Acceptance at cycle T: `arvalid` rises at T+1.
- If `arready`=1 at T+1, `rready` rises at T+2.
- If `rvalid`=1 at T+2, `inst_valid` rises at T+3 and `inst_ready` is high at T+3.
- Minimum fetch latency is 3 cycles; each cycle of AR or R stall adds one cycle.
- Misaligned request accepted at T: `inst_valid`/`inst_err` rise at T+2, with no AXI activity.
- The earliest back-to-back acceptance is the cycle `inst_valid` rises.
- `arvalid` never deasserts before `arready`. `rready` is high only in DATA.
- Reset (asynchronous, any state, including mid-transaction):
  - Immediately: state=IDLE, `arvalid`=0, `rready`=0, `inst_valid`=0, `inst_err`=0, `inst_rdata`=0, `araddr`=RESET_ARADDR.
  - `inst_ready` is 0 while `reset` is high and 1 in the first cycle after release.
- The AXI slave is reset by the same `reset`; no in-flight beat is honoured across reset.

## Test plan
- Aligned fetch, zero-wait slave: `inst_addr`=0x80000004, `rdata`=0x00000013_00100093 -> `araddr`=0x80000000, `inst_rdata`=0x00000000_00000013, `inst_valid` at T+3, `inst_err`=0.
- AR stall: `arready` low for 3 cycles at `inst_addr`=0x80000000 -> `araddr` stable throughout, `inst_valid` at T+6, low word returned, `inst_ready`=0 until then.
- `rresp`=2'b10 on a fetch -> `inst_valid`=1 and `inst_err`=1 with the beat's slice; the next request clears `inst_err` after acceptance.
- Misaligned `inst_addr`=0x80000002 -> no `arvalid`; `inst_valid`=`inst_err`=1 and `inst_rdata`=0 at T+2.
- Hold and ignore: `inst_en` pulsed in ADDR/DATA -> no second AR. After `inst_valid` with `inst_en`=0 for 5 cycles, data stays stable. A back-to-back request at `inst_valid`'s cycle is accepted.
- Reset asserted while in DATA with `rvalid` pending -> all outputs clear immediately; after release `inst_ready`=1 and a fresh fetch of 0x80000008 completes normally.

Source files
------------

// File: rtl/ysyx_22041752_isram_bridge_if.sv
// Fetch handshake plus AXI4-Lite read channels between the IFU/memory side and the isram bridge.
// "slave" is the bridge's view; "master" is the IFU and instruction-memory environment around it.
interface ysyx_22041752_isram_bridge_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64
);
    logic               inst_en;
    logic [ADDR_WD-1:0] inst_addr;
    logic               inst_ready;
    logic               inst_valid;
    logic [DATA_WD-1:0] inst_rdata;
    logic               inst_err;

    logic               arvalid;
    logic               arready;
    logic [ADDR_WD-1:0] araddr;
    logic [2:0]         arprot;

    logic               rvalid;
    logic               rready;
    logic [DATA_WD-1:0] rdata;
    logic [1:0]         rresp;

    modport slave (
        input  inst_en, inst_addr,
        output inst_ready, inst_valid, inst_rdata, inst_err,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport master (
        output inst_en, inst_addr,
        input  inst_ready, inst_valid, inst_rdata, inst_err,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/ysyx_22041752_isram_bridge.sv
// Instruction-side bridge: turns each accepted IF fetch into one AXI4-Lite read and returns
// the addressed instruction slice, held stable until the next accepted fetch.
module ysyx_22041752_isram_bridge #(
    parameter int                 ADDR_WD      = 32,
    parameter int                 DATA_WD      = 64,
    parameter int                 INST_WD      = 32,
    parameter logic [ADDR_WD-1:0] RESET_ARADDR = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    ysyx_22041752_isram_bridge_if.slave   bus
);
    localparam int OFF_W  = $clog2(DATA_WD / 8);
    localparam int NSLICE = DATA_WD / INST_WD;
    localparam logic [ADDR_WD-1:0] ALIGN_MASK = ~ADDR_WD'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OFF_W-1:0]   req_off;
    logic [ADDR_WD-1:0] araddr_q;
    logic               valid_q;
    logic               err_q;
    logic [DATA_WD-1:0] rdata_q;
    logic               accept;
    logic               misaligned;
    logic               arvalid_c;
    logic               rready_c;

    // Word index inside the beat comes from the byte offset above the 4-byte instruction lane.
    function automatic logic [INST_WD-1:0] pick_slice(
        input logic [DATA_WD-1:0] beat,
        input logic [OFF_W-1:0]   off
    );
        logic [INST_WD-1:0] word;
        word = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if ((off >> 2) == OFF_W'(i)) begin
                word = beat[i*INST_WD +: INST_WD];
            end
        end
        return word;
    endfunction

    // Ready is gated by reset so the IFU sees no acceptance window while reset is held.
    assign bus.inst_ready = (state == IDLE) && !reset;
    assign accept         = bus.inst_en && bus.inst_ready;
    assign misaligned     = bus.inst_addr[1:0] != 2'b00;

    assign bus.arvalid    = arvalid_c;
    assign bus.rready     = rready_c;
    assign bus.araddr     = araddr_q;
    assign bus.arprot     = 3'b100;
    assign bus.inst_valid = valid_q;
    assign bus.inst_err   = err_q;
    assign bus.inst_rdata = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arvalid_c = 1'b0;
        rready_c  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = misaligned ? FAULT : ADDR;
                end
            end
            ADDR: begin
                arvalid_c = 1'b1;
                if (bus.arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                rready_c = 1'b1;
                if (bus.rvalid) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_off  <= '0;
            araddr_q <= RESET_ARADDR;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                req_off <= bus.inst_addr[OFF_W-1:0];
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                // Misaligned fetches never reach AXI, so araddr keeps its previous value.
                if (!misaligned) begin
                    araddr_q <= bus.inst_addr & ALIGN_MASK;
                end
            end
            if (state == DATA && bus.rvalid) begin
                rdata_q <= DATA_WD'(pick_slice(bus.rdata, req_off));
                valid_q <= 1'b1;
                err_q   <= bus.rresp != 2'b00;
            end
            if (state == FAULT) begin
                rdata_q <= '0;
                valid_q <= 1'b1;
                err_q   <= 1'b1;
            end
        end
    end

    // Protocol guarantees the rest of the core relies on.
    a_ar_hold : assert property (@(posedge clk) disable iff (reset)
        bus.arvalid && !bus.arready |=> bus.arvalid && $stable(bus.araddr));
    a_one_outstanding : assert property (@(posedge clk) disable iff (reset)
        !(bus.arvalid && bus.rready));
    a_no_accept_busy : assert property (@(posedge clk) disable iff (reset)
        (state != IDLE) |-> !bus.inst_ready);

endmodule

// File: tb/tb_ysyx_22041752_isram_bridge.sv
// Directed bench for the isram bridge: table of fetch vectors plus reset and hold sequences.
module tb_ysyx_22041752_isram_bridge;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ysyx_22041752_isram_bridge_if #(.ADDR_WD(32), .DATA_WD(64)) bus ();

    ysyx_22041752_isram_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] beat;
        logic [1:0]  resp;
        int          ar_wait;
        int          r_wait;
        bit          poke;
        logic [31:0] exp_araddr;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_ar;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drives one request at the current cycle and plays the AXI slave until inst_valid.
    task automatic do_fetch(input vec_t v, input string tag);
        int cyc;
        int lat;
        int ar_seen;
        int r_seen;
        int ar_hs;
        bit ready_bad;
        bit addr_bad;
        lat = -1; ar_seen = 0; r_seen = 0; ar_hs = 0; ready_bad = 0; addr_bad = 0;
        check({tag, " ready_at_req"}, 64'(bus.inst_ready), 64'd1);
        bus.inst_en   = 1'b1;
        bus.inst_addr = v.addr;
        @(posedge clk); #1;
        bus.inst_en   = v.poke;
        bus.inst_addr = v.addr ^ 32'h0000_0100;
        check({tag, " cleared_after_accept"}, {62'd0, bus.inst_valid, bus.inst_err}, 64'd0);
        cyc = 1;
        while (lat < 0 && cyc <= 40) begin
            if (bus.inst_valid) begin
                lat = cyc;
            end else begin
                if (bus.inst_ready) ready_bad = 1'b1;
                bus.arready = bus.arvalid && (ar_seen >= v.ar_wait);
                if (bus.arvalid) begin
                    if (bus.araddr !== v.exp_araddr) addr_bad = 1'b1;
                    if (bus.arready) ar_hs++;
                    ar_seen++;
                end
                bus.rvalid = bus.rready && (r_seen >= v.r_wait);
                bus.rdata  = bus.rvalid ? v.beat : ~v.beat;
                bus.rresp  = bus.rvalid ? v.resp : 2'b00;
                if (bus.rready) r_seen++;
                @(posedge clk); #1;
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                cyc++;
            end
        end
        bus.inst_en = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " rdata"}, bus.inst_rdata, v.exp_rdata);
        check({tag, " err"}, 64'(bus.inst_err), 64'(v.exp_err));
        check({tag, " ready_at_valid"}, 64'(bus.inst_ready), 64'd1);
        check({tag, " ar_handshakes"}, 64'(ar_hs), 64'(v.exp_ar));
        check({tag, " araddr_stable"}, 64'(addr_bad), 64'd0);
        check({tag, " ready_low_busy"}, 64'(ready_bad), 64'd0);
    endtask

    initial begin
        vec_t fresh;
        logic [63:0] held;

        vecs[0] = '{32'h8000_0004, 64'h0000_0013_0010_0093, 2'b00, 0, 0, 1'b0,
                    32'h8000_0000, 64'h0000_0000_0000_0013, 1'b0, 3, 1};
        vecs[1] = '{32'h8000_0000, 64'h0000_0013_0010_0093, 2'b00, 3, 0, 1'b0,
                    32'h8000_0000, 64'h0000_0000_0010_0093, 1'b0, 6, 1};
        vecs[2] = '{32'h8000_000C, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 0, 2, 1'b0,
                    32'h8000_0008, 64'h0000_0000_DEAD_BEEF, 1'b1, 5, 1};
        vecs[3] = '{32'h8000_0002, 64'h1234_5678_9ABC_DEF0, 2'b00, 0, 0, 1'b0,
                    32'h0000_0000, 64'h0, 1'b1, 2, 0};
        vecs[4] = '{32'h8000_0010, 64'h1111_2222_3333_4444, 2'b00, 1, 1, 1'b0,
                    32'h8000_0010, 64'h0000_0000_3333_4444, 1'b0, 5, 1};
        vecs[5] = '{32'h8000_0021, 64'h5555_6666_7777_8888, 2'b00, 0, 0, 1'b0,
                    32'h0000_0000, 64'h0, 1'b1, 2, 0};
        vecs[6] = '{32'h8000_0024, 64'hA5A5_0001_0000_0517, 2'b00, 2, 1, 1'b1,
                    32'h8000_0020, 64'h0000_0000_A5A5_0001, 1'b0, 6, 1};

        reset = 1'b1;
        bus.inst_en = 1'b0; bus.inst_addr = '0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        @(posedge clk); @(posedge clk); #1;
        check("rst arvalid", 64'(bus.arvalid), 64'd0);
        check("rst rready", 64'(bus.rready), 64'd0);
        check("rst inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst inst_err", 64'(bus.inst_err), 64'd0);
        check("rst inst_rdata", bus.inst_rdata, 64'd0);
        check("rst araddr", 64'(bus.araddr), 64'd0);
        check("rst inst_ready", 64'(bus.inst_ready), 64'd0);
        check("arprot", 64'(bus.arprot), 64'd4);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst inst_ready", 64'(bus.inst_ready), 64'd1);

        // Each fetch starts in the cycle the previous one raised inst_valid (back-to-back).
        for (int i = 0; i < 7; i++) begin
            do_fetch(vecs[i], $sformatf("vec%0d", i));
        end

        held = bus.inst_rdata;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d data", k),
                  {bus.inst_rdata[31:0], 29'd0, bus.inst_valid, bus.inst_err, bus.arvalid},
                  {vecs[6].exp_rdata[31:0], 29'd0, 1'b1, 1'b0, 1'b0});
        end
        check("hold rdata_nonzero", 64'(held != 64'd0), 64'd1);

        bus.inst_en = 1'b1; bus.inst_addr = 32'h8000_0000;
        @(posedge clk); #1;
        bus.inst_en = 1'b0;
        check("rstdata arvalid", 64'(bus.arvalid), 64'd1);
        bus.arready = 1'b1;
        @(posedge clk); #1;
        bus.arready = 1'b0;
        check("rstdata rready", 64'(bus.rready), 64'd1);
        bus.rvalid = 1'b1; bus.rdata = 64'hFFFF_FFFF_FFFF_FFFF; bus.rresp = 2'b00;
        #2 reset = 1'b1;
        #1;
        check("midrst arvalid", 64'(bus.arvalid), 64'd0);
        check("midrst rready", 64'(bus.rready), 64'd0);
        check("midrst inst_valid", 64'(bus.inst_valid), 64'd0);
        check("midrst inst_err", 64'(bus.inst_err), 64'd0);
        check("midrst inst_rdata", bus.inst_rdata, 64'd0);
        check("midrst araddr", 64'(bus.araddr), 64'd0);
        check("midrst inst_ready", 64'(bus.inst_ready), 64'd0);
        bus.rvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst ready_after_release", 64'(bus.inst_ready), 64'd1);
        check("midrst still_invalid", 64'(bus.inst_valid), 64'd0);

        fresh = '{32'h8000_0008, 64'h0000_0073_0010_0513, 2'b00, 0, 0, 1'b0,
                  32'h8000_0008, 64'h0000_0000_0010_0513, 1'b0, 3, 1};
        do_fetch(fresh, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
